pwm_duty_sched: RTL and testbench
=================================

// Module: pwm_duty_sched
// PURPOSE
//   Multi-channel PWM controller: one shared free-running period counter drives NCH
//   compare channels. Duty updates arrive over a valid/ready request port, are held in
//   per-channel shadow registers and committed to all channels together at the period
//   boundary, so no channel ever emits a truncated or glitched pulse. Sits between the
//   board switch/host logic and the LED/motor pins.
// PARAMETERS
//   CBITS  19  period counter width; period = 2**CBITS clocks
//   NCH    4   number of PWM channels (1..16)
//   CHW    2   width of req_ch; must satisfy 2**CHW >= NCH
// PORTS
//   clk         in   1         system clock, all logic on rising edge
//   rst         in   1         synchronous reset, active-high
//   req_valid   in   1         duty update request present
//   req_ready   out  1         controller can accept a request this cycle
//   req_ch      in   CHW       target channel index
//   req_duty    in   CBITS     new duty (high-time in clocks per period)
//   req_err     out  1         one-cycle pulse: accepted request had req_ch >= NCH
//   pending     out  NCH       bit i = channel i has an uncommitted shadow value
//   period_strt out  1         one-cycle pulse in the cycle cnt==0 (commit took effect)
//   pwm_out     out  NCH       registered PWM outputs
// BEHAVIOUR
//   Reset (rst=1 at edge): cnt=0, active[*]=0, shadow[*]=0, pending=0, pwm_out=0,
//     req_err=0, period_strt=0. req_ready is 0 while rst is high.
//   Counter: cnt <= cnt+1 every cycle, unsigned, wraps 2**CBITS-1 -> 0 (MAX = all ones).
//   Compare: pwm_out[i] <= (cnt < active[i]), unsigned CBITS-bit compare; one clock
//     latency from cnt value to pin. duty 0 -> constant low; duty MAX -> low one clock
//     per period only.
//   Handshake: req_ready = !rst && (cnt != MAX). Transfer occurs when
//     req_valid && req_ready at a rising edge. Requester may hold valid across a
//     not-ready cycle; payload must stay stable until transfer.
//   Accept, req_ch < NCH: shadow[req_ch] <= req_duty; pending[req_ch] <= 1.
//     Several writes to one channel in one period: last write wins.
//   Accept, req_ch >= NCH: no state change except req_err <= 1 for one cycle.
//   Commit cycle (cnt == MAX, req_ready=0): for every i with pending[i]=1,
//     active[i] <= shadow[i]; pending <= 0. Channels not pending keep active value.
//     New duty is first compared at cnt==0; first pin effect is the following cycle.
//   period_strt <= (cnt == MAX), i.e. asserted in the cycle where cnt==0.
//   Reset mid-period: all state returns to reset values immediately at the edge;
//     pending shadows are discarded; a request valid in the rst cycle is not accepted.
//   No combinational path from req_* to pwm_out; req_ready depends only on cnt and rst.
// TESTING  (bench overrides CBITS=4, NCH=4, CHW=2; period = 16 clocks)
//   Reset 2 cycles, no requests -> pwm_out=0 always; period_strt every 16 clocks,
//     first one 16 cycles after rst falls; req_ready=1 except when cnt==15.
//   Write ch1 duty=5 at cnt=3 -> pending=4'b0010 until commit; pwm_out[1] stays 0 in
//     rest of that period, then high exactly 5 clocks from cycle after cnt==0; pending=0.
//   Write ch2 duty=3 then ch2 duty=9 in same period -> only 9 applied; pwm_out[2]
//     high 9 of 16 clocks; duty=0 -> low, duty=15 -> high 15 of 16.
//   Hold req_valid at cnt==15 -> no transfer that cycle (ready=0); transfer at cnt==0,
//     value commits at end of that (next) period, not the current one.
//   Request req_ch=3 with NCH=3 override -> req_err pulses once, pending and pwm unchanged.
//   Write ch0 duty=8, assert rst at cnt=10 -> after rst: pending=0, active[0]=0,
//     pwm_out[0] stays 0 for full following period; cnt restarts at 0.

Source files
------------

// File: rtl/pwm_duty_sched.sv
// Multi-channel PWM controller: one shared period counter, per-channel compare,
// duty updates buffered in shadow registers and committed together at the period boundary.
module pwm_duty_sched #(
    parameter int CBITS = 19,
    parameter int NCH   = 4,
    parameter int CHW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CHW-1:0]   req_ch,
    input  logic [CBITS-1:0] req_duty,
    output logic             req_err,
    output logic [NCH-1:0]   pending,
    output logic             period_strt,
    output logic [NCH-1:0]   pwm_out
);

    localparam logic [CBITS-1:0] CNT_MAX = {CBITS{1'b1}};
    localparam logic [CHW:0]     NCH_C   = (CHW+1)'(NCH);

    logic [CBITS-1:0]           cnt_q, cnt_d;
    logic [NCH-1:0][CBITS-1:0]  active_q, active_d;
    logic [NCH-1:0][CBITS-1:0]  shadow_q, shadow_d;
    logic [NCH-1:0]             pending_q, pending_d;
    logic [NCH-1:0]             pwm_q, pwm_d;
    logic                       req_err_q, req_err_d;
    logic                       period_strt_q, period_strt_d;
    logic                       at_max_s, accept_s, ch_ok_s;

    // Ready drops in the commit cycle so a write can never race the shadow-to-active copy.
    assign at_max_s  = (cnt_q == CNT_MAX);
    assign req_ready = !rst && !at_max_s;
    assign accept_s  = req_valid && req_ready;
    assign ch_ok_s   = ({1'b0, req_ch} < NCH_C);

    // Counter, shadow/active bookkeeping and status pulses.
    always_comb begin
        cnt_d         = cnt_q + CBITS'(1);
        active_d      = active_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        req_err_d     = accept_s && !ch_ok_s;
        period_strt_d = at_max_s;
        if (at_max_s) begin
            for (int i = 0; i < NCH; i++) begin
                if (pending_q[i]) begin
                    active_d[i] = shadow_q[i];
                end else begin
                    active_d[i] = active_q[i];
                end
            end
            pending_d = '0;
        end else if (accept_s && ch_ok_s) begin
            for (int i = 0; i < NCH; i++) begin
                if (req_ch == CHW'(i)) begin
                    shadow_d[i]  = req_duty;
                    pending_d[i] = 1'b1;
                end else begin
                    shadow_d[i]  = shadow_q[i];
                    pending_d[i] = pending_q[i];
                end
            end
        end else begin
            pending_d = pending_q;
        end
    end

    // Compare stage: pin is a flop so no request path reaches the outputs combinationally.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = (cnt_q < active_q[i]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= '0;
            pwm_q         <= '0;
            req_err_q     <= 1'b0;
            period_strt_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            req_err_q     <= req_err_d;
            period_strt_q <= period_strt_d;
        end
    end

    assign pending     = pending_q;
    assign pwm_out     = pwm_q;
    assign req_err     = req_err_q;
    assign period_strt = period_strt_q;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Scoreboard bench for pwm_duty_sched (CBITS=4): per-period waveform records and
// error-pulse records are queued by the stimulus and popped by independent monitors.
module tb_pwm_duty_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_ch = 2'd0;
    logic [3:0] req_duty = 4'd0;
    logic       req_err;
    logic [3:0] pending;
    logic       period_strt;
    logic [3:0] pwm_out;

    logic       v3 = 1'b0;
    logic       ready3;
    logic [1:0] ch3 = 2'd0;
    logic [3:0] d3 = 4'd0;
    logic       err3;
    logic [2:0] pend3;
    logic       ps3;
    logic [2:0] pwm3;

    pwm_duty_sched #(.CBITS(4), .NCH(4), .CHW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_duty(req_duty), .req_err(req_err), .pending(pending),
        .period_strt(period_strt), .pwm_out(pwm_out)
    );

    pwm_duty_sched #(.CBITS(4), .NCH(3), .CHW(2)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3),
        .req_ch(ch3), .req_duty(d3), .req_err(err3), .pending(pend3),
        .period_strt(ps3), .pwm_out(pwm3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] duty;
        logic [3:0]      pend;
    } win_t;

    typedef struct packed {
        logic [2:0] pend;
        logic [2:0] pwm;
    } err_t;

    win_t win_q[$];
    err_t err_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   tcnt   = 0;

    function automatic logic [15:0] dmask(input logic [3:0] d);
        dmask = (16'd1 << d) - 16'd1;
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push_win(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] p);
        win_t w;
        w.duty[0] = a; w.duty[1] = b; w.duty[2] = c; w.duty[3] = d; w.pend = p;
        win_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tcnt = (tcnt + 1) % 16;
    endtask

    task automatic to_cnt(input int at);
        while (tcnt != at) step();
    endtask

    task automatic next_period();
        to_cnt(15);
        step();
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] duty, input int at);
        to_cnt(at);
        req_valid = 1'b1; req_ch = ch; req_duty = duty;
        step();
        req_valid = 1'b0;
    endtask

    // Window monitor: pin samples from cnt==1 through the next cnt==0 form one period.
    initial begin
        logic [15:0] mask [4];
        logic [15:0] rdy_mask;
        logic [3:0]  pend_prev;
        win_t        e;
        rdy_mask = '0; pend_prev = '0;
        for (int i = 0; i < 4; i++) mask[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 4; i++) mask[i] = '0;
                rdy_mask  = '0;
                pend_prev = '0;
            end else begin
                for (int i = 0; i < 4; i++) mask[i] = {pwm_out[i], mask[i][15:1]};
                rdy_mask = {req_ready, rdy_mask[15:1]};
                check("req_err_main", {15'd0, req_err}, 16'd0);
                if (period_strt) begin
                    if (win_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL window_unexpected: got period_strt expected none at %0t", $time);
                    end else begin
                        e = win_q.pop_front();
                        check("pwm_ch0", mask[0], dmask(e.duty[0]));
                        check("pwm_ch1", mask[1], dmask(e.duty[1]));
                        check("pwm_ch2", mask[2], dmask(e.duty[2]));
                        check("pwm_ch3", mask[3], dmask(e.duty[3]));
                        check("pending_end", {12'd0, pend_prev}, {12'd0, e.pend});
                        check("ready_mask", rdy_mask, 16'hBFFF);
                    end
                end
                pend_prev = pending;
            end
        end
    end

    // Error monitor on the 3-channel instance.
    initial begin
        logic err_prev;
        err_t e;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                err_prev = 1'b0;
            end else begin
                if (err3) begin
                    if (err_prev) begin
                        n_vec++; n_fail++;
                        $display("FAIL err_width: got 2-cycle req_err expected 1-cycle at %0t", $time);
                    end else if (err_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL err_unexpected: got req_err expected none at %0t", $time);
                    end else begin
                        e = err_q.pop_front();
                        check("err_pending", {13'd0, pend3}, {13'd0, e.pend});
                        check("err_pwm", {13'd0, pwm3}, {13'd0, e.pwm});
                    end
                end
                err_prev = err3;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        err_t ee;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tcnt = 0;
        // P0: idle after reset
        push_win(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        next_period();
        // P1: ch1 duty 5 written mid-period
        push_win(4'd0, 4'd0, 4'd0, 4'd0, 4'b0010);
        wr(2'd1, 4'd5, 3);
        next_period();
        // P2: two writes to ch2, last wins; error channel on the NCH=3 instance
        push_win(4'd0, 4'd5, 4'd0, 4'd0, 4'b0100);
        wr(2'd2, 4'd3, 2);
        wr(2'd2, 4'd9, 6);
        to_cnt(8);
        ee.pend = 3'b000; ee.pwm = 3'b000; err_q.push_back(ee);
        v3 = 1'b1; ch3 = 2'd3; d3 = 4'd6;
        step();
        v3 = 1'b0;
        to_cnt(10);
        v3 = 1'b1; ch3 = 2'd2; d3 = 4'd4;
        step();
        ee.pend = 3'b100; ee.pwm = 3'b000; err_q.push_back(ee);
        ch3 = 2'd3; d3 = 4'd11;
        step();
        v3 = 1'b0;
        next_period();
        // P3: ch0 full-scale, ch1 back to zero
        push_win(4'd0, 4'd5, 4'd9, 4'd0, 4'b0011);
        wr(2'd0, 4'd15, 4);
        wr(2'd1, 4'd0, 5);
        next_period();
        // P4/P5: request held across the not-ready commit cycle
        push_win(4'd15, 4'd0, 4'd9, 4'd0, 4'b0000);
        to_cnt(15);
        req_valid = 1'b1; req_ch = 2'd3; req_duty = 4'd7;
        step();
        push_win(4'd15, 4'd0, 4'd9, 4'd0, 4'b1000);
        step();
        req_valid = 1'b0;
        next_period();
        // P6: ch3 now live
        push_win(4'd15, 4'd0, 4'd9, 4'd7, 4'b0000);
        next_period();
        // P7: pending write then reset mid-period with a request present
        wr(2'd0, 4'd8, 3);
        to_cnt(10);
        rst = 1'b1;
        req_valid = 1'b1; req_ch = 2'd1; req_duty = 4'd4;
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        tcnt = 0;
        // P8: everything cleared
        push_win(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        next_period();
        // P9/P10: writes at cnt 0 and 1, boundary duties
        push_win(4'd0, 4'd0, 4'd0, 4'd0, 4'b1100);
        wr(2'd2, 4'd15, 0);
        wr(2'd3, 4'd1, 1);
        next_period();
        push_win(4'd0, 4'd0, 4'd15, 4'd1, 4'b0000);
        next_period();
        for (int k = 0; k < 40 && (win_q.size() != 0 || err_q.size() != 0); k++) begin
            @(posedge clk);
        end
        if (win_q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL window_missing: got %0d unconsumed expected 0", win_q.size());
        end
        if (err_q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL err_missing: got %0d unconsumed expected 0", err_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
